// File: rtl/terminal_pkg.sv
// Shared types and constants for the 80x30 text terminal write path.
package terminal_pkg;

    localparam int TERMINAL_ADDR_MAX   = 2399;
    localparam int TERMINAL_COLUMN_MAX = 80;
    localparam int TERMINAL_ROW_MAX    = 30;
    localparam int ADDR_W              = 12;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    typedef struct packed {
        addr_t      addr;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/terminal_clear_sweeper.sv
// Cell index generator for the full-screen clear; done flags the last cell.
module terminal_clear_sweeper
    import terminal_pkg::*;
#(
    parameter int ADDR_MAX = TERMINAL_ADDR_MAX
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  restart,
    input  logic  advance,
    output addr_t count,
    output logic  done
);

    assign done = (count == addr_t'(ADDR_MAX));

    always_ff @(posedge clock) begin
        if (reset || restart)
            count <= '0;
        else if (advance)
            count <= done ? '0 : count + addr_t'(1);
    end

endmodule

// File: rtl/terminal_write_arbiter.sv
// Single write port arbiter for the terminal buffer: debugger scan vs console,
// with a reset/requested full-screen clear. TERMINAL_ARB_STATS_EN adds dbg_drop_count.
module terminal_write_arbiter
    import terminal_pkg::*;
#(
    parameter int         ADDR_MAX      = TERMINAL_ADDR_MAX,
    parameter int         CON_BURST_MAX = 4,
    parameter logic [7:0] CLEAR_CHAR    = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_data,
    input  logic              dbg_write,
    input  logic              con_valid,
    output logic              con_ready,
    input  logic [ADDR_W-1:0] con_addr,
    input  logic [7:0]        con_data,
    input  logic              clear_req,
    output logic              busy,
    output logic              con_addr_err,
    output logic [ADDR_W-1:0] terminal_addr,
    output logic              terminal_write,
    output logic [7:0]        terminal_data
`ifdef TERMINAL_ARB_STATS_EN
    ,
    output logic [15:0]       dbg_drop_count
`endif
);

    localparam int BURST_W = $clog2(CON_BURST_MAX + 1);

    state_t             state, state_next;
    addr_t              clr_cnt;
    logic               clr_done;
    logic [BURST_W-1:0] burst_cnt;
    logic               con_xfer, dbg_grant, addr_bad;
    wr_req_t            con_req, dbg_req;

    assign con_req  = '{addr: con_addr, data: con_data};
    assign dbg_req  = '{addr: dbg_addr, data: dbg_data};
    assign addr_bad = (con_addr > addr_t'(ADDR_MAX));

    terminal_clear_sweeper #(.ADDR_MAX(ADDR_MAX)) u_sweeper (
        .clock   (clock),
        .reset   (reset),
        .restart (clear_req),
        .advance (state == ST_CLEAR),
        .count   (clr_cnt),
        .done    (clr_done)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_CLEAR;
        else
            state <= state_next;
    end

    // con_ready must never see con_valid; grants are derived from it afterwards.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        con_ready  = 1'b0;
        con_xfer   = 1'b0;
        dbg_grant  = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_done)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                con_ready = !(dbg_write && burst_cnt == BURST_W'(CON_BURST_MAX));
                con_xfer  = con_valid && con_ready;
                dbg_grant = dbg_write && !con_xfer;
            end
            default: state_next = ST_CLEAR;
        endcase
        if (clear_req) begin
            state_next = ST_CLEAR;
            con_ready  = 1'b0;
            con_xfer   = 1'b0;
            dbg_grant  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            terminal_addr  <= '0;
            terminal_data  <= '0;
            terminal_write <= 1'b0;
            con_addr_err   <= 1'b0;
            burst_cnt      <= '0;
        end else begin
            terminal_write <= 1'b0;
            con_addr_err   <= 1'b0;
            if (clear_req) begin
                burst_cnt <= '0;
            end else if (state == ST_CLEAR) begin
                terminal_addr  <= clr_cnt;
                terminal_data  <= CLEAR_CHAR;
                terminal_write <= 1'b1;
                burst_cnt      <= '0;
            end else begin
                if (con_xfer) begin
                    if (addr_bad) begin
                        con_addr_err <= 1'b1;
                    end else begin
                        terminal_addr  <= con_req.addr;
                        terminal_data  <= con_req.data;
                        terminal_write <= 1'b1;
                    end
                end else if (dbg_grant) begin
                    terminal_addr  <= dbg_req.addr;
                    terminal_data  <= dbg_req.data;
                    terminal_write <= 1'b1;
                end
                // Only a console win over a waiting debugger extends the burst.
                if (con_xfer && dbg_write) begin
                    if (burst_cnt != BURST_W'(CON_BURST_MAX))
                        burst_cnt <= burst_cnt + BURST_W'(1);
                end else begin
                    burst_cnt <= '0;
                end
            end
        end
    end

`ifdef TERMINAL_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset)
            dbg_drop_count <= '0;
        else if (dbg_write && !dbg_grant && dbg_drop_count != 16'hFFFF)
            dbg_drop_count <= dbg_drop_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_terminal_write_arbiter.sv
// Bench for terminal_write_arbiter: directed table, corner sequences, random vs model.
module tb_terminal_write_arbiter;

    logic        clock = 1'b0;
    logic        reset, dbg_write, con_valid, clear_req;
    logic [11:0] dbg_addr, con_addr;
    logic [7:0]  dbg_data, con_data;
    logic        con_ready, busy, con_addr_err, terminal_write;
    logic [11:0] terminal_addr;
    logic [7:0]  terminal_data;
`ifdef TERMINAL_ARB_STATS_EN
    logic [15:0] dbg_drop_count;
`endif

    terminal_write_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .dbg_write      (dbg_write),
        .con_valid      (con_valid),
        .con_ready      (con_ready),
        .con_addr       (con_addr),
        .con_data       (con_data),
        .clear_req      (clear_req),
        .busy           (busy),
        .con_addr_err   (con_addr_err),
        .terminal_addr  (terminal_addr),
        .terminal_write (terminal_write),
        .terminal_data  (terminal_data)
`ifdef TERMINAL_ARB_STATS_EN
        ,
        .dbg_drop_count (dbg_drop_count)
`endif
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: screen clearing progress, console streak length, last write.
    bit          m_clearing;
    int          m_idx, m_burst, m_drops;
    logic [11:0] m_addr;
    logic [7:0]  m_data;
    bit          m_write, m_err;

    typedef struct {
        bit          dw;
        logic [11:0] da;
        logic [7:0]  dd;
        bit          cv;
        logic [11:0] ca;
        logic [7:0]  cd;
        bit          x_ready;
        bit          x_write;
        logic [11:0] x_addr;
        logic [7:0]  x_data;
        bit          x_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !m_clearing && !clear_req && !(dbg_write && m_burst == 4);
    endfunction

    task automatic tick();
        bit exp_ready, con_take, dbg_take;
        #1;
        exp_ready = model_ready();
        chk("ready_busy", {30'b0, con_ready, busy}, {30'b0, exp_ready, m_clearing});
        @(posedge clock);
        con_take = con_valid && exp_ready;
        dbg_take = !m_clearing && !clear_req && dbg_write && !con_take;
        if (!reset && dbg_write && !dbg_take && m_drops < 65535) m_drops++;
        m_write = 1'b0;
        m_err   = 1'b0;
        if (reset) begin
            m_addr = '0; m_data = '0;
            m_clearing = 1'b1; m_idx = 0; m_burst = 0; m_drops = 0;
        end else if (clear_req) begin
            m_clearing = 1'b1; m_idx = 0; m_burst = 0;
        end else if (m_clearing) begin
            m_write = 1'b1; m_addr = 12'(m_idx); m_data = 8'h00;
            m_idx++;
            if (m_idx > 2399) begin
                m_clearing = 1'b0; m_idx = 0;
            end
            m_burst = 0;
        end else begin
            if (con_take && con_addr > 12'd2399) begin
                m_err = 1'b1;
            end else if (con_take) begin
                m_write = 1'b1; m_addr = con_addr; m_data = con_data;
            end else if (dbg_take) begin
                m_write = 1'b1; m_addr = dbg_addr; m_data = dbg_data;
            end
            m_burst = (con_take && dbg_write) ? ((m_burst < 4) ? m_burst + 1 : 4) : 0;
        end
        #1;
        chk("terminal", {10'b0, terminal_write, terminal_addr, terminal_data, con_addr_err},
            {10'b0, m_write, m_addr, m_data, m_err});
`ifdef TERMINAL_ARB_STATS_EN
        chk("drop_count", {16'b0, dbg_drop_count}, 32'(m_drops));
`endif
    endtask

    task automatic idle();
        dbg_write = 0; dbg_addr = '0; dbg_data = '0;
        con_valid = 0; con_addr = '0; con_data = '0; clear_req = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        bit   pend, take;
        int   n, first_addr;

        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        m_clearing = 1; m_idx = 0; m_burst = 0; m_drops = 0;
        m_addr = '0; m_data = '0; m_write = 0; m_err = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset clear with the debugger hammering: every cell 0..2399 in order.
        dbg_write = 1; dbg_addr = 12'd7; dbg_data = 8'h55;
        for (int i = 0; i < 2400; i++) begin
            tick();
            chk("clr_stream", {11'b0, terminal_write, terminal_addr, terminal_data, busy},
                {11'b0, 1'b1, 12'(i), 8'h00, (i == 2399) ? 1'b0 : 1'b1});
        end
`ifdef TERMINAL_ARB_STATS_EN
        chk("drop_after_clear", {16'b0, dbg_drop_count}, 32'd2400);
`endif
        idle();

        tbl[0]  = '{0, 12'd0,    8'h00, 1, 12'd85,   8'h41, 1, 1, 12'd85,   8'h41, 0};
        tbl[1]  = '{1, 12'd10,   8'h61, 1, 12'd100,  8'h42, 1, 1, 12'd100,  8'h42, 0};
        tbl[2]  = '{1, 12'd10,   8'h61, 1, 12'd101,  8'h43, 1, 1, 12'd101,  8'h43, 0};
        tbl[3]  = '{1, 12'd10,   8'h61, 1, 12'd102,  8'h44, 1, 1, 12'd102,  8'h44, 0};
        tbl[4]  = '{1, 12'd10,   8'h61, 1, 12'd103,  8'h45, 1, 1, 12'd103,  8'h45, 0};
        tbl[5]  = '{1, 12'd10,   8'h61, 1, 12'd104,  8'h46, 0, 1, 12'd10,   8'h61, 0};
        tbl[6]  = '{1, 12'd11,   8'h62, 1, 12'd104,  8'h46, 1, 1, 12'd104,  8'h46, 0};
        tbl[7]  = '{1, 12'd11,   8'h62, 1, 12'd105,  8'h47, 1, 1, 12'd105,  8'h47, 0};
        tbl[8]  = '{1, 12'd11,   8'h62, 1, 12'd106,  8'h48, 1, 1, 12'd106,  8'h48, 0};
        tbl[9]  = '{1, 12'd11,   8'h62, 1, 12'd107,  8'h49, 1, 1, 12'd107,  8'h49, 0};
        tbl[10] = '{1, 12'd11,   8'h62, 1, 12'd108,  8'h4A, 0, 1, 12'd11,   8'h62, 0};
        tbl[11] = '{0, 12'd0,    8'h00, 1, 12'd2400, 8'h55, 1, 0, 12'd11,   8'h62, 1};
        tbl[12] = '{0, 12'd0,    8'h00, 0, 12'd0,    8'h00, 1, 0, 12'd11,   8'h62, 0};
        tbl[13] = '{1, 12'd2399, 8'h7E, 0, 12'd0,    8'h00, 1, 1, 12'd2399, 8'h7E, 0};
        tbl[14] = '{0, 12'd0,    8'h00, 0, 12'd0,    8'h00, 1, 0, 12'd2399, 8'h7E, 0};
        foreach (tbl[i]) begin
            dbg_write = tbl[i].dw; dbg_addr = tbl[i].da; dbg_data = tbl[i].dd;
            con_valid = tbl[i].cv; con_addr = tbl[i].ca; con_data = tbl[i].cd;
            #1;
            chk($sformatf("tbl%0d_ready", i), {31'b0, con_ready}, {31'b0, tbl[i].x_ready});
            tick();
            chk($sformatf("tbl%0d_out", i), {10'b0, terminal_write, terminal_addr, terminal_data, con_addr_err},
                {10'b0, tbl[i].x_write, tbl[i].x_addr, tbl[i].x_data, tbl[i].x_err});
        end
        idle();

        // Random traffic; console holds its request until it is taken.
        pend = 0;
        for (int k = 0; k < 1500; k++) begin
            if (!pend && $urandom_range(0, 1) == 1) begin
                pend = 1;
                con_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(2400, 4095))
                                                       : 12'($urandom_range(0, 2399));
                con_data = 8'($urandom);
            end
            con_valid = pend;
            dbg_write = ($urandom_range(0, 3) != 0);
            dbg_addr  = 12'($urandom_range(0, 2399));
            dbg_data  = 8'($urandom);
            clear_req = ($urandom_range(0, 499) == 0);
            take = con_valid && model_ready();
            tick();
            if (take) pend = 0;
        end
        idle();
        n = 0;
        while (m_clearing && n < 3000) begin
            tick();
            n++;
        end
        chk("random_drain", {31'b0, busy}, 32'd0);

        // Restart a clear once cell 999 has been written.
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 1000; i++) tick();
        chk("pre_restart", {19'b0, terminal_write, terminal_addr}, {19'b0, 1'b1, 12'd999});
        clear_req = 1;
        tick();
        clear_req = 0;
        chk("restart_busy", {31'b0, busy}, 32'd1);
        n = 0;
        first_addr = -1;
        while (busy && n < 3000) begin
            tick();
            if (first_addr < 0 && terminal_write) first_addr = int'(terminal_addr);
            n++;
        end
        chk("restart_first_addr", 32'(first_addr), 32'd0);
        chk("restart_cycles", 32'(n), 32'd2400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
